// File: rtl/funct_gen_pipe.sv
// funct_gen_pipe: ID-stage ALU funct decoder feeding a small valid/ready FIFO toward EX.
// Decode happens on the input side, so each entry holds a ready-to-use funct, illegal flag and tag.
module funct_gen_pipe #(
    parameter int OP_WIDTH       = 6,
    parameter int FUNCT_WIDTH    = 6,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TAG_WIDTH      = 32,
    parameter int DEPTH          = 2,
    parameter int EXT_ISA        = 1,
    parameter int CNT_WIDTH      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OP_WIDTH-1:0]       in_op,
    input  logic [FUNCT_WIDTH-1:0]    in_funct,
    input  logic [REG_ADDR_WIDTH-1:0] in_rt,
    input  logic [TAG_WIDTH-1:0]      in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [FUNCT_WIDTH-1:0]    out_funct,
    output logic                      out_illegal,
    output logic [TAG_WIDTH-1:0]      out_tag,
    output logic [CNT_WIDTH-1:0]      count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [OP_WIDTH-1:0] OP_SPECIAL = 'h00, OP_REGIMM = 'h01, OP_J = 'h02,
        OP_JAL = 'h03, OP_BEQ = 'h04, OP_BNE = 'h05, OP_ADDIU = 'h09, OP_SLTI = 'h0A,
        OP_SLTIU = 'h0B, OP_ANDI = 'h0C, OP_ORI = 'h0D, OP_XORI = 'h0E, OP_LUI = 'h0F,
        OP_LB = 'h20, OP_LH = 'h21, OP_LW = 'h23, OP_LBU = 'h24, OP_LHU = 'h25,
        OP_SB = 'h28, OP_SH = 'h29, OP_SW = 'h2B;
    localparam logic [FUNCT_WIDTH-1:0] F_NOP = 'h00, F_ADDU = 'h21, F_SUBU = 'h23,
        F_AND = 'h24, F_OR = 'h25, F_XOR = 'h26, F_SLT = 'h2A, F_SLTU = 'h2B;
    localparam logic EXT = (EXT_ISA != 0);

    logic [FUNCT_WIDTH-1:0] funct_mem [DEPTH];
    logic                   illegal_mem [DEPTH];
    logic [TAG_WIDTH-1:0]   tag_mem [DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [FUNCT_WIDTH-1:0] dec_funct;
    logic                   dec_illegal, regimm_ok, full, push, pop;

    assign regimm_ok = EXT && (in_rt == REG_ADDR_WIDTH'('h00) || in_rt == REG_ADDR_WIDTH'('h01) ||
                               in_rt == REG_ADDR_WIDTH'('h10) || in_rt == REG_ADDR_WIDTH'('h11));

    always_comb begin
        dec_funct   = F_NOP;
        dec_illegal = 1'b0;
        case (in_op)
            OP_SPECIAL:                                   dec_funct = in_funct;
            OP_LUI, OP_JAL:                               dec_funct = F_OR;
            OP_LB, OP_LBU, OP_LW, OP_SB, OP_SW, OP_ADDIU: dec_funct = F_ADDU;
            OP_J:                                         dec_funct = F_NOP;
            OP_BEQ, OP_BNE:                               dec_funct = EXT ? F_SUBU : F_NOP;
            OP_ANDI:  begin dec_funct = EXT ? F_AND  : F_NOP; dec_illegal = !EXT; end
            OP_ORI:   begin dec_funct = EXT ? F_OR   : F_NOP; dec_illegal = !EXT; end
            OP_XORI:  begin dec_funct = EXT ? F_XOR  : F_NOP; dec_illegal = !EXT; end
            OP_SLTI:  begin dec_funct = EXT ? F_SLT  : F_NOP; dec_illegal = !EXT; end
            OP_SLTIU: begin dec_funct = EXT ? F_SLTU : F_NOP; dec_illegal = !EXT; end
            OP_LH, OP_LHU, OP_SH: begin dec_funct = EXT ? F_ADDU : F_NOP; dec_illegal = !EXT; end
            OP_REGIMM: begin dec_funct = regimm_ok ? F_SLT : F_NOP; dec_illegal = !regimm_ok; end
            default:                                      dec_illegal = 1'b1;
        endcase
    end

    // No pass-through: a pop while full only frees space for the following cycle.
    assign full      = (count == CNT_WIDTH'(DEPTH));
    assign in_ready  = !full && !flush && !rst;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_funct   = out_valid ? funct_mem[rd_ptr]   : F_NOP;
    assign out_illegal = out_valid ? illegal_mem[rd_ptr] : 1'b0;
    assign out_tag     = out_valid ? tag_mem[rd_ptr]     : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            funct_mem[wr_ptr]   <= dec_funct;
            illegal_mem[wr_ptr] <= dec_illegal;
            tag_mem[wr_ptr]     <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        end
    end
endmodule
